clock_time_core: RTL

Consumer of the one-cycle-per-second tick produced by the seconds divider. Maintains time of day as BCD hours/minutes/seconds, 24-hour format, with synchronous load and per-field adjust. Emits minute, hour and day rollover pulses for the display, alarm and calendar blocks downstream.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/bcd_mod_counter.sv | 50 +++++
 rtl/clock_time_core.sv | 118 +++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared constants and BCD helpers for the time-of-day counter.
// Both helpers assume an 8-bit, two-digit BCD value.
package clock_pkg;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_23 = 8'h23;

    // Both digits must be decimal, and the value must not exceed max.
    // Once the digits are decimal, a plain binary compare is also a BCD compare.
    function automatic logic bcd_valid(input logic [7:0] value, input logic [7:0] max);
        logic ok;
        ok = (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
        return ok;
    endfunction

    // Returns {wrap, next}. The value wraps to 00 when it equals max.
    function automatic logic [8:0] bcd_inc(input logic [7:0] value, input logic [7:0] max);
        logic [8:0] res;
        if (value == max) begin
            res = {1'b1, 8'h00};
        end else if (value[3:0] == 4'd9) begin
            res = {1'b0, value[7:4] + 4'd1, 4'd0};
        end else begin
            res = {1'b0, value[7:4], value[3:0] + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// One two-digit BCD field that counts 00..MAX and can be loaded.
// wrap_o is asserted in the cycle whose step takes the field from MAX back to 00.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MAX = BCD_59,
    parameter logic [7:0] RST = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       inc_i,
    input  logic       carry_in_i,
    output logic [7:0] value_o,
    output logic       wrap_o
);

    logic [7:0] value_q;
    logic [7:0] value_d;
    logic [8:0] inc_res_s;
    logic       step_s;

    // Next value: a load takes priority over an adjust or carry step.
    always_comb begin
        value_d   = value_q;
        inc_res_s = bcd_inc(value_q, MAX);
        step_s    = inc_i | carry_in_i;
        if (load_i) begin
            value_d = load_val_i;
        end else if (step_s) begin
            value_d = inc_res_s[7:0];
        end else begin
            value_d = value_q;
        end
    end

    // Field register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= RST;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;
    assign wrap_o  = step_s & ~load_i & inc_res_s[8];

endmodule

// File: rtl/clock_time_core.sv
// BCD 24-hour time of day, driven by the 1 Hz tick. Supports load, per-field
// adjust and hold, and produces minute, hour and day rollover pulses.
module clock_time_core
    import clock_pkg::*;
#(
    parameter logic [7:0] RST_HOUR = 8'h00,
    parameter logic [7:0] RST_MIN  = 8'h00,
    parameter logic [7:0] RST_SEC  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sec_tick,
    input  logic       hold,
    input  logic       set_load,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       min_carry,
    output logic       hour_carry,
    output logic       day_carry,
    output logic       load_err
);

    logic pend_q, pend_d;
    logic min_carry_q, min_carry_d;
    logic hour_carry_q, hour_carry_d;
    logic day_carry_q, day_carry_d;
    logic load_err_q, load_err_d;

    logic set_valid_s, load_ok_s, adj_min_s, adj_hour_s, any_adj_s;
    logic eff_tick_s, apply_tick_s;
    logic sec_wrap_s, min_wrap_s, hour_wrap_s;
    logic min_cin_s, hour_cin_s;

    // Priority: a valid load wins, then adjusts, then the tick (deferred if an adjust is present).
    always_comb begin
        set_valid_s  = bcd_valid(set_hour, BCD_23) && bcd_valid(set_min, BCD_59)
                       && bcd_valid(set_sec, BCD_59);
        load_ok_s    = set_load & set_valid_s;
        load_err_d   = set_load & ~set_valid_s;
        adj_min_s    = inc_min & ~load_ok_s;
        adj_hour_s   = inc_hour & ~load_ok_s;
        any_adj_s    = adj_min_s | adj_hour_s;
        eff_tick_s   = (sec_tick | pend_q) & ~hold;
        apply_tick_s = eff_tick_s & ~load_ok_s & ~any_adj_s;
        min_cin_s    = apply_tick_s & sec_wrap_s;
        hour_cin_s   = min_cin_s & min_wrap_s;
        min_carry_d  = min_cin_s;
        hour_carry_d = hour_cin_s;
        day_carry_d  = hour_cin_s & hour_wrap_s;
        if (hold || load_ok_s) begin
            pend_d = 1'b0;
        end else begin
            pend_d = eff_tick_s & any_adj_s;
        end
    end

    // Pending tick and the one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= 1'b0;
            min_carry_q  <= 1'b0;
            hour_carry_q <= 1'b0;
            day_carry_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            min_carry_q  <= min_carry_d;
            hour_carry_q <= hour_carry_d;
            day_carry_q  <= day_carry_d;
            load_err_q   <= load_err_d;
        end
    end

    bcd_mod_counter #(.MAX(BCD_59), .RST(RST_SEC)) u_sec (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_ok_s),
        .load_val_i (set_sec),
        .inc_i      (apply_tick_s),
        .carry_in_i (1'b0),
        .value_o    (sec),
        .wrap_o     (sec_wrap_s)
    );

    bcd_mod_counter #(.MAX(BCD_59), .RST(RST_MIN)) u_min (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_ok_s),
        .load_val_i (set_min),
        .inc_i      (adj_min_s),
        .carry_in_i (min_cin_s),
        .value_o    (min),
        .wrap_o     (min_wrap_s)
    );

    bcd_mod_counter #(.MAX(BCD_23), .RST(RST_HOUR)) u_hour (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_ok_s),
        .load_val_i (set_hour),
        .inc_i      (adj_hour_s),
        .carry_in_i (hour_cin_s),
        .value_o    (hour),
        .wrap_o     (hour_wrap_s)
    );

    assign min_carry  = min_carry_q;
    assign hour_carry = hour_carry_q;
    assign day_carry  = day_carry_q;
    assign load_err   = load_err_q;

endmodule
